// File: rtl/load_unit.sv
// RV32 load unit: issues word-aligned data-memory reads, then extracts
// and sign/zero-extends the addressed byte or halfword for write-back.
module load_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_ALUout,
  output logic        o_DM_CS,
  output logic [31:0] o_DM_addr,
  input  logic        i_DM_ready,
  input  logic        i_DM_rvalid,
  input  logic [31:0] i_DM_DO,
  output logic        o_stall,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_data,
  output logic        o_misalign
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] data_q, data_d;
  logic        mis_q, mis_d;

  logic        legal;
  logic        misal;
  logic        stall;
  logic        cs;
  logic [31:0] byte_w;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;

  always_comb begin
    legal = 1'b0;
    misal = 1'b0;
    case (i_funct3)
      F3_LB, F3_LBU: legal = 1'b1;
      F3_LH, F3_LHU: begin
        legal = 1'b1;
        misal = i_ALUout[0];
      end
      F3_LW: begin
        legal = 1'b1;
        misal = |i_ALUout[1:0];
      end
      default: legal = 1'b0;
    endcase
  end

  assign byte_w   = i_DM_DO >> {addr_q[1:0], 3'b000};
  assign byte_sel = byte_w[7:0];
  assign half_sel = addr_q[1] ? i_DM_DO[31:16]
                              : i_DM_DO[15:0];

  always_comb begin
    case (f3_q)
      F3_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  ext = {24'b0, byte_sel};
      F3_LH:   ext = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  ext = {16'b0, half_sel};
      default: ext = i_DM_DO;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    data_d  = data_q;
    mis_d   = 1'b0;
    stall   = 1'b0;
    cs      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_load && legal) begin
          if (misal) begin
            mis_d = 1'b1;
          end else begin
            stall   = 1'b1;
            addr_d  = i_ALUout;
            f3_d    = i_funct3;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        cs    = 1'b1;
        if (i_DM_ready) begin
          if (i_DM_rvalid) begin
            data_d  = ext;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (i_DM_rvalid) begin
          data_d  = ext;
          state_d = DONE;
        end
      end
      DONE: begin
        // i_load here is the retiring instruction, never a new one
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      data_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
    end
  end

  // IDLE stall is combinational on i_load, so reset must mask it
  assign o_stall    = stall & i_rst_n;
  assign o_DM_CS    = cs;
  assign o_DM_addr  = cs ? {addr_q[31:2], 2'b00} : 32'b0;
  assign o_wb_valid = (state_q == DONE);
  assign o_wb_data  = data_q;
  assign o_misalign = mis_q;

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed scenarios plus random
// traffic compared every cycle against a transaction-level model.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [2:0]  f3 = 3'b0;
  logic [31:0] alu = 32'b0;
  logic        ready = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] dout = 32'b0;
  logic        cs;
  logic [31:0] dm_addr;
  logic        stall;
  logic        wbv;
  logic [31:0] wbd;
  logic        mis;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_unit dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_load      (load),
    .i_funct3    (f3),
    .i_ALUout    (alu),
    .o_DM_CS     (cs),
    .o_DM_addr   (dm_addr),
    .i_DM_ready  (ready),
    .i_DM_rvalid (rvalid),
    .i_DM_DO     (dout),
    .o_stall     (stall),
    .o_wb_valid  (wbv),
    .o_wb_data   (wbd),
    .o_misalign  (mis)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // model: one outstanding transaction described by a few flags
  bit          m_pend = 0;
  bit          m_acked = 0;
  bit          m_ret = 0;
  bit          m_mis = 0;
  logic [31:0] m_addr = 0;
  logic [2:0]  m_f3 = 0;
  logic [31:0] m_data = 0;

  function automatic bit legal_f3(input logic [2:0] f);
    return f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic bit aligned(input logic [2:0] f,
                                 input logic [31:0] a);
    int unsigned size;
    size = 32'd1 << f[1:0];
    return (a % size) == 0;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = d >> (8 * a[1:0]);
    h = d >> (16 * a[1]);
    case (f)
      3'd0:    return {{24{b[7]}}, b[7:0]};
      3'd4:    return {24'b0, b[7:0]};
      3'd1:    return {{16{h[15]}}, h[15:0]};
      3'd5:    return {16'b0, h[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic bit m_idle();
    return !m_pend && !m_ret;
  endfunction

  function automatic bit m_accept();
    return rst_n && m_idle() && load && legal_f3(f3)
           && aligned(f3, alu);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend  <= 0;
      m_acked <= 0;
      m_ret   <= 0;
      m_mis   <= 0;
      m_addr  <= 0;
      m_f3    <= 0;
      m_data  <= 0;
    end else begin
      m_mis <= m_idle() && load && legal_f3(f3)
               && !aligned(f3, alu);
      if (m_ret) begin
        m_ret <= 0;
      end else if (m_pend && (m_acked || ready) && rvalid) begin
        m_data <= extract(m_f3, m_addr, dout);
        m_pend <= 0;
        m_ret  <= 1;
      end else if (m_pend && ready) begin
        m_acked <= 1;
      end
      if (m_accept()) begin
        m_pend  <= 1;
        m_acked <= 0;
        m_addr  <= alu;
        m_f3    <= f3;
      end
    end
  end

  always @(negedge clk) begin
    chk("stall", 32'(stall), 32'(m_accept() || m_pend));
    chk("cs", 32'(cs), 32'(m_pend && !m_acked));
    chk("dm_addr", dm_addr,
        (m_pend && !m_acked) ? {m_addr[31:2], 2'b00} : 32'b0);
    chk("wb_valid", 32'(wbv), 32'(m_ret));
    chk("wb_data", wbd, m_data);
    chk("misalign", 32'(mis), 32'(m_mis));
  end

  initial begin
    step();
    step();
    chk("rst_cs", 32'(cs), 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_wbv", 32'(wbv), 0);
    chk("rst_wbd", wbd, 0);
    chk("rst_mis", 32'(mis), 0);
    rst_n = 1'b1;
    step();

    // LB at 0x103, ready+rvalid together
    load = 1; f3 = 3'd0; alu = 32'h103;
    @(negedge clk); chk("lb_stall_T", 32'(stall), 1);
    step();
    ready = 1; rvalid = 1; dout = 32'h80FF_1234;
    @(negedge clk);
    chk("lb_cs", 32'(cs), 1);
    chk("lb_addr", dm_addr, 32'h100);
    chk("lb_stall_T1", 32'(stall), 1);
    step();
    ready = 0; rvalid = 0;
    @(negedge clk);
    chk("lb_wbv", 32'(wbv), 1);
    chk("lb_data", wbd, 32'hFFFF_FF80);
    chk("lb_stall_T2", 32'(stall), 0);
    step();
    load = 0;
    @(negedge clk); chk("lb_wbv_off", 32'(wbv), 0);
    step();

    // LHU at 0x2002, rvalid three cycles after ready
    load = 1; f3 = 3'd5; alu = 32'h2002;
    @(negedge clk); chk("lhu_stall_T", 32'(stall), 1);
    step();
    ready = 1;
    @(negedge clk); chk("lhu_stall_T1", 32'(stall), 1);
    step();
    ready = 0;
    @(negedge clk); chk("lhu_stall_T2", 32'(stall), 1);
    step();
    @(negedge clk); chk("lhu_stall_T3", 32'(stall), 1);
    step();
    rvalid = 1; dout = 32'hBEEF_0000;
    @(negedge clk); chk("lhu_stall_T4", 32'(stall), 1);
    step();
    rvalid = 0;
    @(negedge clk);
    chk("lhu_wbv", 32'(wbv), 1);
    chk("lhu_data", wbd, 32'h0000_BEEF);
    chk("lhu_stall_T5", 32'(stall), 0);
    step();
    load = 0;
    step();

    // misaligned LW
    load = 1; f3 = 3'd2; alu = 32'h1006;
    @(negedge clk);
    chk("mis_stall", 32'(stall), 0);
    chk("mis_cs", 32'(cs), 0);
    step();
    load = 0;
    @(negedge clk);
    chk("mis_pulse", 32'(mis), 1);
    chk("mis_cs1", 32'(cs), 0);
    step();
    @(negedge clk); chk("mis_pulse_off", 32'(mis), 0);
    step();

    // LH at 0x40 with memory not ready for three cycles
    load = 1; f3 = 3'd1; alu = 32'h40;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("lh_hold_cs", 32'(cs), 1);
      chk("lh_hold_addr", dm_addr, 32'h40);
    end
    step();
    ready = 1; rvalid = 1; dout = 32'h0000_8001;
    @(negedge clk); chk("lh_cs_acc", 32'(cs), 1);
    step();
    ready = 0; rvalid = 0;
    @(negedge clk);
    chk("lh_wbv", 32'(wbv), 1);
    chk("lh_data", wbd, 32'hFFFF_8001);
    step();
    load = 0;
    step();

    // reset while waiting for read data aborts the load
    load = 1; f3 = 3'd2; alu = 32'h200;
    @(negedge clk);
    step();
    ready = 1;
    step();
    ready = 0;
    #2;
    rst_n = 0; load = 0;
    #1;
    chk("abort_stall", 32'(stall), 0);
    chk("abort_cs", 32'(cs), 0);
    chk("abort_addr", dm_addr, 0);
    chk("abort_wbv", 32'(wbv), 0);
    chk("abort_wbd", wbd, 0);
    chk("abort_mis", 32'(mis), 0);
    step();
    rst_n = 1; rvalid = 1; dout = 32'hDEAD_BEEF;
    @(negedge clk); chk("abort_cs2", 32'(cs), 0);
    step();
    rvalid = 0;
    @(negedge clk);
    chk("abort_nowbv", 32'(wbv), 0);
    chk("abort_wbd2", wbd, 0);
    step();
    load = 1; f3 = 3'd2; alu = 32'h204;
    step();
    ready = 1; rvalid = 1; dout = 32'h1234_5678;
    step();
    ready = 0; rvalid = 0;
    @(negedge clk);
    chk("relw_wbv", 32'(wbv), 1);
    chk("relw_data", wbd, 32'h1234_5678);
    step();
    load = 0;
    step();

    // illegal funct3 ignored; i_load held in DONE ignored
    load = 1; f3 = 3'd3; alu = 32'h0;
    @(negedge clk);
    chk("ill_stall", 32'(stall), 0);
    chk("ill_cs", 32'(cs), 0);
    step();
    @(negedge clk);
    chk("ill_cs1", 32'(cs), 0);
    chk("ill_mis", 32'(mis), 0);
    step();
    f3 = 3'd2; alu = 32'h300;
    step();
    ready = 1; rvalid = 1; dout = 32'hCAFE_F00D;
    step();
    ready = 0; rvalid = 0;
    @(negedge clk); chk("hold_wbv", 32'(wbv), 1);
    step();
    load = 0;
    @(negedge clk);
    chk("hold_cs", 32'(cs), 0);
    chk("hold_stall", 32'(stall), 0);
    chk("hold_data", wbd, 32'hCAFE_F00D);
    step();

    // random traffic with occasional asynchronous resets
    for (int i = 0; i < 4000; i++) begin
      load   = ($urandom_range(0, 2) != 0);
      f3     = 3'($urandom_range(0, 7));
      alu    = $urandom;
      ready  = ($urandom_range(0, 2) == 0);
      rvalid = ($urandom_range(0, 2) == 0);
      dout   = $urandom;
      if ($urandom_range(0, 149) == 0) begin
        #3;
        rst_n = 0;
        step();
        rst_n = 1;
      end else begin
        step();
      end
    end
    load = 0; ready = 0; rvalid = 0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
